// File: rtl/serial_transmitter_4bits.sv
// Parallel-to-serial framer: start bit (0), WIDTH data bits, stop bit (1).
// Every output is registered; reset_async aborts any frame in flight.
module serial_transmitter_4bits #(
    parameter int WIDTH     = 4,
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             reset_async,
    input  logic             inicio,
    input  logic [WIDTH-1:0] In,
    output logic             serial_out,
    output logic             ocupado,
    output logic             listo
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t           state, state_n;
    logic [WIDTH-1:0] shreg, shreg_n;
    logic [CW-1:0]    cnt, cnt_n;
    logic             serial_n, ocupado_n, listo_n;
    logic             cur_bit;
    logic [WIDTH-1:0] shifted;

    // The bit on the line always comes from the same end of the shift register.
    assign cur_bit = LSB_FIRST ? shreg[0] : shreg[WIDTH-1];
    assign shifted = LSB_FIRST ? (shreg >> 1) : (shreg << 1);

    always_ff @(posedge clk or posedge reset_async) begin
        if (reset_async) begin
            state      <= IDLE;
            shreg      <= '0;
            cnt        <= '0;
            serial_out <= 1'b1;
            ocupado    <= 1'b0;
            listo      <= 1'b0;
        end else begin
            state      <= state_n;
            shreg      <= shreg_n;
            cnt        <= cnt_n;
            serial_out <= serial_n;
            ocupado    <= ocupado_n;
            listo      <= listo_n;
        end
    end

    always_comb begin
        state_n   = state;
        shreg_n   = shreg;
        cnt_n     = cnt;
        serial_n  = 1'b1;
        ocupado_n = 1'b0;
        listo_n   = 1'b0;
        case (state)
            IDLE: begin
                if (inicio) begin
                    shreg_n   = In;
                    cnt_n     = '0;
                    serial_n  = 1'b0;
                    ocupado_n = 1'b1;
                    state_n   = START;
                end
            end
            START: begin
                // Leaving the start bit: first data bit goes out on this edge.
                serial_n  = cur_bit;
                shreg_n   = shifted;
                cnt_n     = CW'(1);
                ocupado_n = 1'b1;
                state_n   = DATA;
            end
            DATA: begin
                ocupado_n = 1'b1;
                if (cnt == CW'(WIDTH)) begin
                    serial_n = 1'b1;
                    state_n  = STOP;
                end else begin
                    serial_n = cur_bit;
                    shreg_n  = shifted;
                    cnt_n    = cnt + CW'(1);
                end
            end
            STOP: begin
                listo_n = 1'b1;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end
endmodule

// File: tb/tb_serial_transmitter_4bits.sv
// Bench for serial_transmitter_4bits: LSB-first and MSB-first instances share inputs.
module tb_serial_transmitter_4bits;
    localparam int W = 4;

    logic         clk_tb = 1'b0;
    logic         reset_async;
    logic         inicio;
    logic [W-1:0] din;
    logic         serial_l, ocu_l, lis_l;
    logic         serial_m, ocu_m, lis_m;

    int errors = 0;
    int checks = 0;

    always #5 clk_tb = ~clk_tb;

    serial_transmitter_4bits #(.WIDTH(W), .LSB_FIRST(1'b1)) dut_l (
        .clk(clk_tb), .reset_async(reset_async), .inicio(inicio), .In(din),
        .serial_out(serial_l), .ocupado(ocu_l), .listo(lis_l)
    );
    serial_transmitter_4bits #(.WIDTH(W), .LSB_FIRST(1'b0)) dut_m (
        .clk(clk_tb), .reset_async(reset_async), .inicio(inicio), .In(din),
        .serial_out(serial_m), .ocupado(ocu_m), .listo(lis_m)
    );

    typedef struct {
        logic         ini;
        logic [W-1:0] d;
        logic         sl;
        logic         sm;
        logic         ocu;
        logic         lis;
    } vec_t;

    vec_t vt[$];

    // Reference model: position inside the frame (0 = idle, 1 = start bit,
    // 2..W+1 = data bits, W+2 = stop bit) and the captured word.
    int           m_pos;
    logic [W-1:0] m_word;
    logic         m_listo;

    function automatic vec_t mk(logic ini, logic [W-1:0] d, logic sl, logic sm,
                                logic ocu, logic lis);
        vec_t v;
        v.ini = ini; v.d = d; v.sl = sl; v.sm = sm; v.ocu = ocu; v.lis = lis;
        return v;
    endfunction

    task automatic chk1(string nm, logic act, logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk(string nm, logic sl, logic sm, logic ocu, logic lis);
        chk1({nm, ".serial_lsb"}, serial_l, sl);
        chk1({nm, ".serial_msb"}, serial_m, sm);
        chk1({nm, ".ocupado_lsb"}, ocu_l, ocu);
        chk1({nm, ".ocupado_msb"}, ocu_m, ocu);
        chk1({nm, ".listo_lsb"}, lis_l, lis);
        chk1({nm, ".listo_msb"}, lis_m, lis);
    endtask

    function automatic logic model_line(bit lsb);
        int i;
        if (m_pos == 0 || m_pos == W + 2) return 1'b1;
        if (m_pos == 1) return 1'b0;
        i = m_pos - 2;
        return lsb ? m_word[i] : m_word[W-1-i];
    endfunction

    task automatic step_model(logic ini, logic [W-1:0] d);
        inicio = ini;
        din    = d;
        @(posedge clk_tb);
        #1;
        m_listo = 1'b0;
        if (m_pos == 0) begin
            if (ini) begin
                m_pos  = 1;
                m_word = d;
            end
        end else if (m_pos == W + 2) begin
            m_pos   = 0;
            m_listo = 1'b1;
        end else begin
            m_pos++;
        end
        chk("model", model_line(1'b1), model_line(1'b0), m_pos != 0, m_listo);
    endtask

    initial begin
        // Reset with inicio high and clock running.
        reset_async = 1'b1;
        inicio      = 1'b1;
        din         = 4'hF;
        @(posedge clk_tb); #1;
        chk("reset_edge", 1'b1, 1'b1, 1'b0, 1'b0);
        @(negedge clk_tb);
        chk("reset_mid", 1'b1, 1'b1, 1'b0, 1'b0);
        #2;
        reset_async = 1'b0;
        inicio      = 1'b0;

        // 1011 frame (rows 0-8), A with mid-frame In/inicio changes (9-16),
        // back-to-back F then 0 with inicio held (17-31).
        vt.push_back(mk(0, 4'hB, 1, 1, 0, 0));
        vt.push_back(mk(1, 4'hB, 0, 0, 1, 0));
        vt.push_back(mk(0, 4'hB, 1, 1, 1, 0));
        vt.push_back(mk(0, 4'hB, 1, 0, 1, 0));
        vt.push_back(mk(0, 4'hB, 0, 1, 1, 0));
        vt.push_back(mk(0, 4'hB, 1, 1, 1, 0));
        vt.push_back(mk(0, 4'hB, 1, 1, 1, 0));
        vt.push_back(mk(0, 4'hB, 1, 1, 0, 1));
        vt.push_back(mk(0, 4'hB, 1, 1, 0, 0));
        vt.push_back(mk(1, 4'hA, 0, 0, 1, 0));
        vt.push_back(mk(0, 4'h5, 0, 1, 1, 0));
        vt.push_back(mk(1, 4'h5, 1, 0, 1, 0));
        vt.push_back(mk(0, 4'h5, 0, 1, 1, 0));
        vt.push_back(mk(1, 4'h5, 1, 0, 1, 0));
        vt.push_back(mk(1, 4'h5, 1, 1, 1, 0));
        vt.push_back(mk(0, 4'h5, 1, 1, 0, 1));
        vt.push_back(mk(0, 4'h5, 1, 1, 0, 0));
        vt.push_back(mk(1, 4'hF, 0, 0, 1, 0));
        for (int k = 0; k < 5; k++) vt.push_back(mk(1, 4'h0, 1, 1, 1, 0));
        vt.push_back(mk(1, 4'h0, 1, 1, 0, 1));
        vt.push_back(mk(1, 4'h0, 0, 0, 1, 0));
        for (int k = 0; k < 4; k++) vt.push_back(mk(0, 4'h0, 0, 0, 1, 0));
        vt.push_back(mk(0, 4'h0, 1, 1, 1, 0));
        vt.push_back(mk(0, 4'h0, 1, 1, 0, 1));
        vt.push_back(mk(0, 4'h0, 1, 1, 0, 0));

        foreach (vt[i]) begin
            inicio = vt[i].ini;
            din    = vt[i].d;
            @(posedge clk_tb); #1;
            chk($sformatf("vec%0d", i), vt[i].sl, vt[i].sm, vt[i].ocu, vt[i].lis);
        end

        // Reset during the third data bit aborts the frame at once.
        inicio = 1'b1;
        din    = 4'h6;
        @(posedge clk_tb); #1;
        inicio = 1'b0;
        repeat (3) @(posedge clk_tb);
        #2;
        reset_async = 1'b1;
        #1;
        chk("rst_abort", 1'b1, 1'b1, 1'b0, 1'b0);
        @(posedge clk_tb); #1;
        chk("rst_hold", 1'b1, 1'b1, 1'b0, 1'b0);
        reset_async = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk_tb); #1;
            chk("post_rst_idle", 1'b1, 1'b1, 1'b0, 1'b0);
        end

        // Clean frame after the abort, then randomized traffic.
        m_pos   = 0;
        m_word  = '0;
        m_listo = 1'b0;
        step_model(1'b1, 4'h6);
        for (int k = 0; k < W + 3; k++) step_model(1'b0, 4'h9);
        for (int k = 0; k < 400; k++)
            step_model($urandom_range(0, 2) == 0, W'($urandom));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
